// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Signal bundle between the pipeline datapath and the hazard
//                controller. The slave modport is the controller's view; the
//                master modport is the datapath's view.
//  Signals     :
//    id_rs, id_rt, id_uses_rt        IF/ID source register fields
//    ex_mem_read, ex_rt              ID/EX load indication and destination
//    mem_branch, mem_zero, mem_jump  EX/MEM redirect inputs
//    mem_access                      EX/MEM data-memory access
//    pc_we, pc_sel                   PC load enable and source select
//    *_we, *_flush                   pipeline buffer enables and bubble loads
//    mem_busy                        multi-cycle memory stall in progress
//    stall_cnt, flush_cnt            saturating performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch;
  logic        mem_zero;
  logic        mem_jump;
  logic        mem_access;

  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        mem_busy;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch, mem_zero, mem_jump, mem_access,
    output pc_we, pc_sel, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_busy, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch, mem_zero, mem_jump, mem_access,
    input  pc_we, pc_sel, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_busy, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencing controller for the five-stage MIPS core.
//                Resolves load-use hazards, MEM-stage branch/jump redirects
//                and multi-cycle data-memory accesses, and keeps saturating
//                stall / redirect counters for performance debug.
//  Parameters  :
//    MEM_LAT     data-memory latency in cycles (1..16, 1 = no memory stall)
//  Ports       :
//    clk         pipeline clock, rising edge
//    rst         synchronous active-high reset
//    hz          hazard_ctrl_if.slave bundle (hazard inputs, pipeline
//                enables/flushes, PC select, mem_busy, counters)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  // WAIT reload value: the entry cycle is the first stall, so MEM_LAT-2
  // further stall cycles remain before the release cycle.
  localparam int       c_LAT_M2      = (MEM_LAT >= 2) ? (MEM_LAT - 2) : 0;
  localparam logic [3:0] c_CNT_RELOAD = c_LAT_M2[3:0];
  localparam bit       c_MEM_MULTI   = (MEM_LAT > 1);
  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

  localparam logic [1:0] c_PC_SEQ    = 2'b00;
  localparam logic [1:0] c_PC_BRANCH = 2'b01;
  localparam logic [1:0] c_PC_JUMP   = 2'b10;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic        w_redirect;
  logic        w_load_use;
  logic        w_redirect_taken;

  logic        w_pc_we;
  logic [1:0]  w_pc_sel;
  logic        w_ifid_we;
  logic        w_idex_we;
  logic        w_exmem_we;
  logic        w_ifid_flush;
  logic        w_idex_flush;
  logic        w_exmem_flush;
  logic        w_memwb_flush;
  logic        w_mem_busy;

  // A taken branch or any jump sitting in EX/MEM.
  assign w_redirect = hz.mem_jump | (hz.mem_branch & hz.mem_zero);

  // Load in ID/EX whose destination feeds the instruction in IF/ID.
  // Register 0 is hardwired, so a load into it never creates a hazard.
  assign w_load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    w_redirect_taken = 1'b0;
    w_pc_we          = 1'b1;
    w_pc_sel         = c_PC_SEQ;
    w_ifid_we        = 1'b1;
    w_idex_we        = 1'b1;
    w_exmem_we       = 1'b1;
    w_ifid_flush     = 1'b0;
    w_idex_flush     = 1'b0;
    w_exmem_flush    = 1'b0;
    w_memwb_flush    = 1'b0;
    w_mem_busy       = 1'b0;

    if (rst) begin
      // Hold the PC and load bubbles everywhere so the pipeline comes out
      // of reset empty.
      w_pc_we       = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_memwb_flush = 1'b1;
      state_d       = S_RUN;
      cnt_d         = 4'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (hz.mem_access && c_MEM_MULTI) begin
            // Freeze everything up to EX/MEM; MEM/WB receives bubbles
            // until the access completes.
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_we     = 1'b0;
            w_exmem_we    = 1'b0;
            w_memwb_flush = 1'b1;
            w_mem_busy    = 1'b1;
            cnt_d         = c_CNT_RELOAD;
            state_d       = S_WAIT;
          end else if (w_redirect) begin
            // Three younger instructions are on the wrong path.
            w_pc_sel         = hz.mem_jump ? c_PC_JUMP : c_PC_BRANCH;
            w_ifid_flush     = 1'b1;
            w_idex_flush     = 1'b1;
            w_exmem_flush    = 1'b1;
            w_redirect_taken = 1'b1;
          end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle; a bubble enters ID/EX.
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
          end
        end

        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_we     = 1'b0;
            w_exmem_we    = 1'b0;
            w_memwb_flush = 1'b1;
            w_mem_busy    = 1'b1;
            cnt_d         = cnt_q - 4'd1;
          end else begin
            // Release cycle: the access completes and EX/MEM advances.
            // Hazard inputs still reflect the frozen pipeline and are not
            // acted on here.
            state_d = S_RUN;
          end
        end

        default: begin
          state_d = S_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!w_pc_we && (stall_cnt_q != c_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (w_redirect_taken && (flush_cnt_q != c_CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign hz.pc_we       = w_pc_we;
  assign hz.pc_sel      = w_pc_sel;
  assign hz.ifid_we     = w_ifid_we;
  assign hz.idex_we     = w_idex_we;
  assign hz.exmem_we    = w_exmem_we;
  assign hz.ifid_flush  = w_ifid_flush;
  assign hz.idex_flush  = w_idex_flush;
  assign hz.exmem_flush = w_exmem_flush;
  assign hz.memwb_flush = w_memwb_flush;
  assign hz.mem_busy    = w_mem_busy;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Three instances with
//                MEM_LAT = 1, 4 and 8 share one input stream; a cycle-level
//                reference model predicts every output of every instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       mem_branch;
    logic       mem_zero;
    logic       mem_jump;
    logic       mem_access;
  } in_t;

  typedef struct {
    in_t         v;
    logic [10:0] exp;
  } vec_t;

  // Control word: {pc_we, pc_sel[1:0], ifid_we, idex_we, exmem_we,
  //                ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_busy}
  localparam logic [10:0] C_DEF   = 11'b1_00_111_0000_0;
  localparam logic [10:0] C_RST   = 11'b0_00_111_1111_0;
  localparam logic [10:0] C_STALL = 11'b0_00_000_0001_1;
  localparam logic [10:0] C_LU    = 11'b0_00_011_0100_0;
  localparam logic [10:0] C_BR    = 11'b1_01_111_1110_0;
  localparam logic [10:0] C_JMP   = 11'b1_10_111_1110_0;

  localparam int LATS [3] = '{1, 4, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  cur = '0;

  logic [10:0] ctrl [3];
  logic [15:0] scnt [3];
  logic [15:0] fcnt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    hazard_ctrl_if u_if ();
    hazard_ctrl #(.MEM_LAT(L)) u_dut (.clk(clk), .rst(rst), .hz(u_if));
    assign u_if.id_rs       = cur.id_rs;
    assign u_if.id_rt       = cur.id_rt;
    assign u_if.id_uses_rt  = cur.id_uses_rt;
    assign u_if.ex_mem_read = cur.ex_mem_read;
    assign u_if.ex_rt       = cur.ex_rt;
    assign u_if.mem_branch  = cur.mem_branch;
    assign u_if.mem_zero    = cur.mem_zero;
    assign u_if.mem_jump    = cur.mem_jump;
    assign u_if.mem_access  = cur.mem_access;
    assign ctrl[g] = {u_if.pc_we, u_if.pc_sel, u_if.ifid_we, u_if.idex_we,
                      u_if.exmem_we, u_if.ifid_flush, u_if.idex_flush,
                      u_if.exmem_flush, u_if.memwb_flush, u_if.mem_busy};
    assign scnt[g] = u_if.stall_cnt;
    assign fcnt[g] = u_if.flush_cnt;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles still owed to an outstanding memory access
  // (stall cycles plus the final release cycle) and the two counters.
  int m_owed [3];
  int m_scnt [3];
  int m_fcnt [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_ctrl(input int k, input in_t v, input logic r);
    logic redirect;
    logic lu;
    redirect = v.mem_jump || (v.mem_branch && v.mem_zero);
    lu = v.ex_mem_read && (v.ex_rt != 5'd0) &&
         ((v.ex_rt == v.id_rs) || (v.id_uses_rt && (v.ex_rt == v.id_rt)));
    if (r)                                  return C_RST;
    if (m_owed[k] > 1)                      return C_STALL;
    if (m_owed[k] == 1)                     return C_DEF;
    if (v.mem_access && (LATS[k] > 1))      return C_STALL;
    if (redirect)                           return v.mem_jump ? C_JMP : C_BR;
    if (lu)                                 return C_LU;
    return C_DEF;
  endfunction

  // Compare every instance against the model, away from the rising edge.
  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ctrl[lat%0d]", LATS[k]), 32'(ctrl[k]), 32'(exp_ctrl(k, cur, rst)));
      chk($sformatf("stall_cnt[lat%0d]", LATS[k]), 32'(scnt[k]), 32'(m_scnt[k]));
      chk($sformatf("flush_cnt[lat%0d]", LATS[k]), 32'(fcnt[k]), 32'(m_fcnt[k]));
    end
  endtask

  // Advance the model across the coming edge, then the clock itself.
  task automatic advance();
    logic [10:0] e;
    for (int k = 0; k < 3; k++) begin
      e = exp_ctrl(k, cur, rst);
      if (rst) begin
        m_owed[k] = 0;
        m_scnt[k] = 0;
        m_fcnt[k] = 0;
      end else begin
        if (!e[10] && m_scnt[k] < 65535) m_scnt[k]++;
        if (e[9:8] != 2'b00 && m_fcnt[k] < 65535) m_fcnt[k]++;
        if (m_owed[k] > 0)             m_owed[k]--;
        else if (e == C_STALL)         m_owed[k] = LATS[k] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    cur = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                             input logic mr, input logic [4:0] ert, input logic br,
                             input logic z, input logic j, input logic acc);
    in_t t;
    t.id_rs = rs; t.id_rt = rt; t.id_uses_rt = urt; t.ex_mem_read = mr;
    t.ex_rt = ert; t.mem_branch = br; t.mem_zero = z; t.mem_jump = j;
    t.mem_access = acc;
    return t;
  endfunction

  vec_t tbl [12];

  initial begin
    // Vectors with expected control for the MEM_LAT = 1 instance.
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), C_DEF};
    tbl[1]  = '{mk(5, 0, 0, 1, 5, 0, 0, 0, 0), C_LU};
    tbl[2]  = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 0), C_DEF};
    tbl[3]  = '{mk(3, 7, 0, 1, 7, 0, 0, 0, 0), C_DEF};
    tbl[4]  = '{mk(3, 7, 1, 1, 7, 0, 0, 0, 0), C_LU};
    tbl[5]  = '{mk(0, 0, 0, 0, 0, 1, 1, 0, 0), C_BR};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0), C_DEF};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0), C_JMP};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 1, 1, 1, 0), C_JMP};
    tbl[9]  = '{mk(5, 0, 0, 1, 5, 1, 1, 0, 0), C_BR};
    tbl[10] = '{mk(5, 5, 1, 0, 5, 0, 0, 0, 0), C_DEF};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), C_DEF};

    for (int k = 0; k < 3; k++) begin
      m_owed[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end

    // Initialise the counters before anything is compared.
    rst = 1'b1;
    advance();

    // Reset: two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      cur = in_t'($urandom);
      sample();
      chk("reset ctrl", 32'(ctrl[1]), 32'(C_RST));
      chk("reset stall_cnt", 32'(scnt[1]), 32'd0);
      chk("reset flush_cnt", 32'(fcnt[1]), 32'd0);
      advance();
    end
    rst = 1'b0;
    cur = '0;
    sample();
    chk("post-reset defaults", 32'(ctrl[1]), 32'(C_DEF));
    advance();

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cur = tbl[i].v;
      sample();
      chk($sformatf("table[%0d]", i), 32'(ctrl[0]), 32'(tbl[i].exp));
      advance();
    end

    // Load-use lasts exactly one cycle; stall_cnt = 1 afterwards.
    do_reset();
    cur = mk(5, 0, 0, 1, 5, 0, 0, 0, 0);
    sample();
    chk("load-use stall", 32'(ctrl[0]), 32'(C_LU));
    advance();
    cur = '0;
    sample();
    chk("load-use released", 32'(ctrl[0]), 32'(C_DEF));
    chk("load-use stall_cnt", 32'(scnt[0]), 32'd1);
    advance();

    // Branch redirect counts one flush.
    do_reset();
    cur = mk(0, 0, 0, 0, 0, 1, 1, 0, 0);
    sample();
    chk("branch redirect", 32'(ctrl[0]), 32'(C_BR));
    advance();
    cur = '0;
    sample();
    chk("branch flush_cnt", 32'(fcnt[0]), 32'd1);
    advance();

    // MEM_LAT = 4: three stall cycles (jump ignored), then release.
    do_reset();
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cur.mem_jump = (i == 1);
      sample();
      chk($sformatf("mem stall cycle %0d", i), 32'(ctrl[1]), 32'(C_STALL));
      advance();
    end
    cur.mem_jump = 1'b0;
    sample();
    chk("mem release", 32'(ctrl[1]), 32'(C_DEF));
    advance();
    cur = '0;
    sample();
    chk("mem stall_cnt", 32'(scnt[1]), 32'd3);
    chk("mem flush_cnt", 32'(fcnt[1]), 32'd0);
    advance();

    // MEM_LAT = 8: reset on the third stall cycle returns to RUN.
    do_reset();
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("lat8 stall %0d", i), 32'(ctrl[2]), 32'(C_STALL));
      advance();
    end
    cur = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("lat8 after reset %0d", i), 32'(ctrl[2]), 32'(C_DEF));
      advance();
    end

    // Randomised traffic, biased so register fields collide often.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cur.id_rs       = 5'($urandom_range(0, 3));
      cur.id_rt       = 5'($urandom_range(0, 3));
      cur.id_uses_rt  = 1'($urandom);
      cur.ex_mem_read = 1'($urandom);
      cur.ex_rt       = 5'($urandom_range(0, 3));
      cur.mem_branch  = ($urandom_range(0, 3) == 0);
      cur.mem_zero    = 1'($urandom);
      cur.mem_jump    = ($urandom_range(0, 7) == 0);
      cur.mem_access  = ($urandom_range(0, 5) == 0);
      rst             = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;

    // Saturation: a persistent load-use stalls every cycle.
    do_reset();
    cur = mk(5, 0, 0, 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      tick();
    end
    sample();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_cnt saturated lat%0d", LATS[k]), 32'(scnt[k]), 32'h0000FFFF);
    end
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves three hazard classes: load-use, control redirects from branches and jumps resolved in the MEM stage, and multi-cycle data-memory accesses. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- MEM_LAT, 1: data-memory access latency in cycles. Legal range 1..16; 1 means no memory stall.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in IF/ID
- id_rt  in  5  rt field of the instruction in IF/ID
- id_uses_rt  in  1  the IF/ID instruction reads rt as a source
- ex_mem_read  in  1  MemRead bit of the ID/EX M field
- ex_rt  in  5  destination rt of the ID/EX instruction
- mem_branch  in  1  Branch bit of the EX/MEM M field
- mem_zero  in  1  EX/MEM ALU zero flag
- mem_jump  in  1  EX/MEM jump bit
- mem_access  in  1  EX/MEM instruction performs a data-memory read or write
- pc_we  out  1  PC load enable
- pc_sel  out  2  PC source: 00 PC+4, 01 EX/MEM branch target, 10 EX/MEM jump target
- ifid_we, idex_we, exmem_we  out  1 each  buffer load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero control fields) instead of the input
- mem_busy  out  1  high while a multi-cycle memory stall is in progress
- stall_cnt  out  16  stall cycles counted, saturating at 16'hFFFF
- flush_cnt  out  16  redirects counted, saturating at 16'hFFFF

## Operation
- The FSM has two states, RUN and WAIT, plus a 4-bit down-counter `cnt`.
- All outputs except the counters are combinational from the state, `cnt` and the inputs.
- Defaults: all `*_we` = 1, all flushes = 0, pc_sel = 00, mem_busy = 0.
- In RUN the checks below are evaluated in priority order; the first match applies.
  1. **Memory stall.** Condition: mem_access = 1 and MEM_LAT > 1.
     - Outputs: pc_we = ifid_we = idex_we = exmem_we = 0, memwb_flush = 1, mem_busy = 1.
     - Next state: cnt <= MEM_LAT-2, state <= WAIT.
  2. **Redirect.** Condition: mem_jump = 1, or mem_branch & mem_zero = 1.
     - Outputs: pc_sel = 10 if mem_jump, else 01.
     - ifid_flush = idex_flush = exmem_flush = 1, which squashes three wrong-path instructions.
     - flush_cnt increments by 1.
  3. **Load-use.** Condition: ex_mem_read = 1 and ex_rt != 0 and (ex_rt == id_rs, or id_uses_rt and ex_rt == id_rt).
     - Outputs: pc_we = ifid_we = 0, idex_flush = 1. This inserts one bubble.
- In WAIT:
  - If cnt != 0: same outputs as the memory-stall case in RUN, and cnt decrements. The redirect and load-use inputs are ignored.
  - If cnt == 0: release cycle with default outputs; state <= RUN. The redirect and load-use checks are not evaluated in this cycle.
- stall_cnt increments in every cycle where pc_we = 0 while rst = 0.
- While rst = 1:
  - pc_we = 0, all `*_we` = 1, all flushes = 1, pc_sel = 00, mem_busy = 0.
  - Next state: state <= RUN, cnt <= 0, stall_cnt <= 0, flush_cnt <= 0.

## Timing
- Load-use costs exactly 1 stall cycle; the dependent instruction leaves ID on the following cycle.
- A memory access costs MEM_LAT-1 stall cycles. EX/MEM advances on the release cycle; the total from entering EX/MEM to leaving it is MEM_LAT cycles.
- A redirect takes effect on the next edge: the PC loads the target and three bubbles are present in IF/ID, ID/EX and EX/MEM.
- With MEM_LAT = 1, WAIT is never entered.
- Reset mid-WAIT: the first cycle after rst falls is in RUN with cnt = 0 and default outputs, unless the inputs trigger a hazard.
- Counters saturate at 16'hFFFF and never wrap.

## Test plan
- **Reset.** rst = 1 for 2 cycles with random inputs -> pc_we = 0, all flushes = 1, stall_cnt = flush_cnt = 0. After release, the defaults apply.
- **Load-use.** ex_mem_read = 1, ex_rt = 5, id_rs = 5 for one cycle -> pc_we = ifid_we = 0, idex_flush = 1 for exactly 1 cycle; stall_cnt = 1.
  - Repeat with ex_rt = 0 -> no stall.
  - Repeat with a match on id_rt only and id_uses_rt = 0 -> no stall.
- **Redirect.** mem_branch = 1, mem_zero = 1 -> pc_sel = 01 plus a three-stage flush; flush_cnt = 1. mem_jump = 1 -> pc_sel = 10.
  - Redirect together with a load-use match in the same cycle -> redirect only; idex_flush = 1, pc_we = 1.
- **Memory latency, MEM_LAT = 4.** mem_access held high -> mem_busy high and all enables low for exactly 3 cycles, then one release cycle with exmem_we = 1; stall_cnt = 3.
  - Assert mem_jump during the stall -> ignored.
- **Reset during WAIT (MEM_LAT = 8).** Pulse rst on the 3rd stall cycle -> the next cycle is in RUN with mem_busy = 0.
- **Saturation.** Hold a load-use condition for 65,540 cycles -> stall_cnt stops at 16'hFFFF.
